// File: rtl/trivium_uart_rx.sv
// trivium_uart_rx: 8N1 UART receiver front end for the Trivium cipher tile.
// Optional macro TRIVIUM_UART_PARITY_EN switches the frame format to 8E1
// and drives rx_parity_err; without it rx_parity_err is tied to 0.
module trivium_uart_rx #(
   parameter int unsigned CLKS_PER_BIT = 87
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_frame_err,
   output logic       rx_parity_err,
   output logic       rx_busy
);

   localparam int unsigned CNT_W = 16;
   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef TRIVIUM_UART_PARITY_EN
      S_PARITY,
`endif
      S_STOP,
      S_BREAK
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       data_q, data_d;
   logic             valid_q, valid_d;
   logic             ferr_q, ferr_d;
   logic             busy_q, busy_d;
   logic             sync1_q, rx_s_q;
`ifdef TRIVIUM_UART_PARITY_EN
   logic             par_bad_q, par_bad_d;
   logic             perr_q, perr_d;
`endif

   // Two-flop synchroniser for the asynchronous serial pin (idles high).
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b1;
         rx_s_q  <= 1'b1;
      end else begin
         sync1_q <= rx;
         rx_s_q  <= sync1_q;
      end
   end

   // Next-state, baud timing, deserialisation and strobe generation.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_W'(1);
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
`ifdef TRIVIUM_UART_PARITY_EN
      par_bad_d = par_bad_q;
      perr_d    = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (!rx_s_q) state_d = S_START;
         end
         S_START: begin
            if (cnt_q == HALF_M1) begin
               cnt_d   = '0;
               bit_d   = '0;
`ifdef TRIVIUM_UART_PARITY_EN
               par_bad_d = 1'b0;
`endif
               state_d = rx_s_q ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (cnt_q == BIT_M1) begin
               cnt_d   = '0;
               shift_d = {rx_s_q, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
`ifdef TRIVIUM_UART_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end
            end
         end
`ifdef TRIVIUM_UART_PARITY_EN
         S_PARITY: begin
            if (cnt_q == BIT_M1) begin
               cnt_d     = '0;
               par_bad_d = rx_s_q ^ (^shift_q);
               state_d   = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (cnt_q == BIT_M1) begin
               cnt_d = '0;
               if (rx_s_q) begin
                  state_d = S_IDLE;
`ifdef TRIVIUM_UART_PARITY_EN
                  if (par_bad_q) begin
                     perr_d = 1'b1;
                  end else begin
                     data_d  = shift_q;
                     valid_d = 1'b1;
                  end
`else
                  data_d  = shift_q;
                  valid_d = 1'b1;
`endif
               end else begin
                  ferr_d  = 1'b1;
                  state_d = S_BREAK;
               end
            end
         end
         S_BREAK: begin
            cnt_d = '0;
            if (rx_s_q) state_d = S_IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // State and output registers; reset abandons any frame and clears rx_data.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         busy_q  <= 1'b0;
`ifdef TRIVIUM_UART_PARITY_EN
         par_bad_q <= 1'b0;
         perr_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         busy_q  <= busy_d;
`ifdef TRIVIUM_UART_PARITY_EN
         par_bad_q <= par_bad_d;
         perr_q    <= perr_d;
`endif
      end
   end

   assign rx_data      = data_q;
   assign rx_valid     = valid_q;
   assign rx_frame_err = ferr_q;
   assign rx_busy      = busy_q;
`ifdef TRIVIUM_UART_PARITY_EN
   assign rx_parity_err = perr_q;
`else
   assign rx_parity_err = 1'b0;
`endif

endmodule

// File: doc/trivium_uart_rx.md
# trivium_uart_rx

Serial receive front end for the Trivium stream-cipher tile. It deserialises 8N1 UART frames from a dedicated input pin into bytes and presents each byte to the cipher core as `rx_data` with a single-cycle `rx_valid` strobe. The cipher core loads key/IV material and plaintext from it. The block is fully synchronous to the tile clock and contains its own input synchroniser, baud timer and frame checker.

## Interface
- `CLKS_PER_BIT`, default 87: clock cycles per UART bit (10 MHz / 115200). Legal range 4..65535.
- `clk`  in  1  tile clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `rx`  in  1  asynchronous serial line; idle high, LSB first.
- `rx_data`  out  8  last correctly received byte; held until the next good frame.
- `rx_valid`  out  1  one-cycle pulse: `rx_data` was updated this cycle.
- `rx_frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `rx_parity_err`  out  1  one-cycle pulse: parity mismatch. Constant 0 unless `TRIVIUM_UART_PARITY_EN` is defined.
- `rx_busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- Input path: 2-flop synchroniser `rx` → `rx_s`. Both flops reset to 1. All decisions use `rx_s`.
- Baud counter: 16-bit, counts 0..CLKS_PER_BIT-1. Reloads to 0 on each state entry.
- Bit counter: 3-bit.
- FSM states: IDLE, START, DATA, PARITY (only with macro), STOP, BREAK.
- IDLE → START: when `rx_s`=0.
- START: waits CLKS_PER_BIT/2 (floor) cycles to reach mid-bit, then samples.
  - `rx_s`=1 at the sample: false start, return to IDLE with no strobe.
  - `rx_s`=0: go to DATA.
- DATA: samples every CLKS_PER_BIT cycles. Each sample shifts into the MSB of the shift register (LSB-first reconstruction). After the 8th sample, goes to PARITY (macro defined) or STOP.
- PARITY: samples one bit and compares it with the XOR of the 8 data bits (even parity). A mismatch sets an internal error flag.
- STOP: samples one bit.
  - `rx_s`=1 and no parity error: load `rx_data`, pulse `rx_valid`, go to IDLE.
  - `rx_s`=1 with a parity error: pulse `rx_parity_err`, keep `rx_data` unchanged, go to IDLE.
  - `rx_s`=0: pulse `rx_frame_err`, keep `rx_data` unchanged, go to BREAK.
- BREAK: stays until `rx_s`=1, then goes to IDLE. This covers a line held low.
- The strobes `rx_valid`, `rx_frame_err` and `rx_parity_err` are mutually exclusive and never asserted for more than 1 cycle.

## Timing
- Reset values: `rx_data`=0x00, `rx_valid`=0, `rx_frame_err`=0, `rx_parity_err`=0, `rx_busy`=0, FSM=IDLE, counters=0.
- Reset mid-frame: the frame is abandoned, the block returns to IDLE with no strobe, and `rx_data` is cleared.
- Start detection: `rx_busy` rises 3 cycles after the falling edge at the pin (2 synchroniser cycles + 1 register cycle).
- Sample point n (start=0, data 1..8, stop=9, or 10 with parity) is at T_start + 2 + CLKS_PER_BIT/2 + n·CLKS_PER_BIT. T_start is the cycle of the pin falling edge.
- Strobe latency: the strobe is registered and asserts 1 cycle after the stop sample. `rx_data` changes in that same cycle.
- Back-to-back frames: IDLE is re-entered half a bit before the end of the stop bit. A start edge that immediately follows a stop bit is therefore detected with no lost frame.
- Baud tolerance: ±4 % total clock mismatch without error at CLKS_PER_BIT ≥ 16.

## Configuration
- `TRIVIUM_UART_PARITY_EN` defined: frames are 8E1. The PARITY state exists and `rx_parity_err` is driven.
- Undefined: frames are 8N1. The PARITY state and parity logic are compiled out, and `rx_parity_err` is tied to 0.

## Test plan
All scenarios use CLKS_PER_BIT=8.
- Byte 0xA5 sent as 8N1 → `rx_valid` high for exactly 1 cycle and `rx_data`=0xA5. The pulse lands at the cycle computed from the Timing formula, and `rx_busy` then falls.
- Line low for 2 cycles only (glitch) → START rejects it, no strobe, `rx_busy` returns to 0 within 8 cycles, `rx_data` unchanged.
- Byte 0x3C with stop bit driven 0, line then held low 40 cycles before going high → one `rx_frame_err` pulse, `rx_data` keeps its previous value. `rx_busy` stays high until 3 cycles after the line goes high.
- Back-to-back frames 0x00, 0xFF, 0x81 with no idle gap → three `rx_valid` pulses with matching data, and no error strobes.
- `rst` asserted for 1 cycle during data bit 4 of 0x55, then frame 0x12 sent → no strobe for the aborted frame, `rx_data`=0x00 after reset, then 0x12 with one `rx_valid`.
- With `TRIVIUM_UART_PARITY_EN`: 0x07 with parity bit 1 → `rx_valid`, `rx_data`=0x07. 0x07 with parity bit 0 → `rx_parity_err` pulse and `rx_data` unchanged.
